// File: rtl/rv32i_pkg.sv
// Shared widths and one-hot bit positions for the RV32I execute stage.
package rv32i_pkg;

    localparam int unsigned ALU_WIDTH       = 14;
    localparam int unsigned OPCODE_WIDTH    = 11;
    localparam int unsigned EXCEPTION_WIDTH = 4;
    localparam int unsigned XLEN            = 32;

    // ALU op one-hot bit positions
    localparam int unsigned ADD  = 0;
    localparam int unsigned SUB  = 1;
    localparam int unsigned SLT  = 2;
    localparam int unsigned SLTU = 3;
    localparam int unsigned XOR  = 4;
    localparam int unsigned OR   = 5;
    localparam int unsigned AND  = 6;
    localparam int unsigned SLL  = 7;
    localparam int unsigned SRL  = 8;
    localparam int unsigned SRA  = 9;
    localparam int unsigned EQ   = 10;
    localparam int unsigned NEQ  = 11;
    localparam int unsigned GE   = 12;
    localparam int unsigned GEU  = 13;

    // Opcode class one-hot bit positions
    localparam int unsigned RTYPE  = 0;
    localparam int unsigned ITYPE  = 1;
    localparam int unsigned LOAD   = 2;
    localparam int unsigned STORE  = 3;
    localparam int unsigned BRANCH = 4;
    localparam int unsigned JAL    = 5;
    localparam int unsigned JALR   = 6;
    localparam int unsigned LUI    = 7;
    localparam int unsigned AUIPC  = 8;
    localparam int unsigned SYSTEM = 9;
    localparam int unsigned FENCE  = 10;

    // Exception one-hot bit positions
    localparam int unsigned ILLEGAL = 0;
    localparam int unsigned ECALL   = 1;
    localparam int unsigned EBREAK  = 2;
    localparam int unsigned MRET    = 3;

    typedef logic [ALU_WIDTH-1:0]       alu_t;
    typedef logic [OPCODE_WIDTH-1:0]    opcode_t;
    typedef logic [EXCEPTION_WIDTH-1:0] exception_t;
    typedef logic [XLEN-1:0]            word_t;

endpackage

// File: rtl/rv32i_alu_if.sv
// Decoder-to-execute and execute-to-memory bundle; master is the surrounding pipeline, slave the execute stage.
interface rv32i_alu_if;
    import rv32i_pkg::*;

    alu_t       i_alu;
    logic [4:0] i_rs1_addr;
    word_t      i_rs1;
    word_t      i_rs2;
    word_t      i_imm;
    logic [2:0] i_funct3;
    opcode_t    i_opcode;
    exception_t i_exception;
    word_t      i_pc;
    logic [4:0] i_rd_addr;
    logic       i_ce;
    logic       i_stall;
    logic       i_force_stall;
    logic       i_flush;

    logic [4:0]  o_rs1_addr;
    word_t       o_rs1;
    word_t       o_rs2;
    logic [11:0] o_imm;
    logic [2:0]  o_funct3;
    opcode_t     o_opcode;
    exception_t  o_exception;
    word_t       o_y;
    word_t       o_pc;
    word_t       o_next_pc;
    logic        o_change_pc;
    logic        o_wr_rd;
    logic [4:0]  o_rd_addr;
    word_t       o_rd;
    logic        o_rd_valid;
    logic        o_stall_from_alu;
    logic        o_ce;
    logic        o_stall;
    logic        o_flush;

    modport master (
        output i_alu, i_rs1_addr, i_rs1, i_rs2, i_imm, i_funct3, i_opcode, i_exception,
               i_pc, i_rd_addr, i_ce, i_stall, i_force_stall, i_flush,
        input  o_rs1_addr, o_rs1, o_rs2, o_imm, o_funct3, o_opcode, o_exception, o_y,
               o_pc, o_next_pc, o_change_pc, o_wr_rd, o_rd_addr, o_rd, o_rd_valid,
               o_stall_from_alu, o_ce, o_stall, o_flush
    );

    modport slave (
        input  i_alu, i_rs1_addr, i_rs1, i_rs2, i_imm, i_funct3, i_opcode, i_exception,
               i_pc, i_rd_addr, i_ce, i_stall, i_force_stall, i_flush,
        output o_rs1_addr, o_rs1, o_rs2, o_imm, o_funct3, o_opcode, o_exception, o_y,
               o_pc, o_next_pc, o_change_pc, o_wr_rd, o_rd_addr, o_rd, o_rd_valid,
               o_stall_from_alu, o_ce, o_stall, o_flush
    );

endinterface

// File: rtl/rv32i_alu.sv
// RV32I execute stage: ALU, branch/jump target, rd write-back value, registered for the memory stage.
// Optional macro ALU_FORWARD_EN: when defined, o_rd_valid flags o_rd as usable for forwarding.
module rv32i_alu
    import rv32i_pkg::*;
(
    input  logic         i_clk,
    input  logic         i_rst_n,
    rv32i_alu_if.slave   bus
);

    logic    stall;
    logic    update;
    word_t   op_a;
    word_t   op_b;
    logic [4:0] shamt;
    word_t   y;
    word_t   rd_val;
    word_t   next_pc;
    logic    wr_rd;
    logic    change_pc;

    logic    ce_d;
    logic    wr_rd_d;
    logic    change_pc_d;
    logic    rd_valid_d;
    opcode_t opcode_d;

    assign stall  = bus.i_stall | bus.i_force_stall;
    assign update = bus.i_ce & ~stall;

    // Operand selection: PC-relative ops use pc as a, register-register ops use rs2 as b.
    always_comb begin
        op_a = bus.i_rs1;
        op_b = bus.i_imm;
        if (bus.i_opcode[JAL] | bus.i_opcode[AUIPC]) op_a = bus.i_pc;
        if (bus.i_opcode[RTYPE] | bus.i_opcode[BRANCH]) op_b = bus.i_rs2;
        shamt = op_b[4:0];
    end

    // ALU datapath; the decoder guarantees at most one op bit set.
    always_comb begin
        y = '0;
        if (bus.i_alu[ADD])       y = op_a + op_b;
        else if (bus.i_alu[SUB])  y = op_a - op_b;
        else if (bus.i_alu[SLT])  y = XLEN'($signed(op_a) < $signed(op_b));
        else if (bus.i_alu[SLTU]) y = XLEN'(op_a < op_b);
        else if (bus.i_alu[XOR])  y = op_a ^ op_b;
        else if (bus.i_alu[OR])   y = op_a | op_b;
        else if (bus.i_alu[AND])  y = op_a & op_b;
        else if (bus.i_alu[SLL])  y = op_a << shamt;
        else if (bus.i_alu[SRL])  y = op_a >> shamt;
        else if (bus.i_alu[SRA])  y = XLEN'($signed(op_a) >>> shamt);
        else if (bus.i_alu[EQ])   y = XLEN'(op_a == op_b);
        else if (bus.i_alu[NEQ])  y = XLEN'(op_a != op_b);
        else if (bus.i_alu[GE])   y = XLEN'($signed(op_a) >= $signed(op_b));
        else if (bus.i_alu[GEU])  y = XLEN'(op_a >= op_b);
    end

    // Write-back value and redirect target for the current instruction.
    always_comb begin
        rd_val    = '0;
        wr_rd     = 1'b0;
        next_pc   = bus.i_pc + bus.i_imm;
        change_pc = 1'b0;

        if (bus.i_opcode[RTYPE] | bus.i_opcode[ITYPE]) begin
            rd_val = y;
            wr_rd  = 1'b1;
        end else if (bus.i_opcode[JAL] | bus.i_opcode[JALR]) begin
            rd_val = bus.i_pc + XLEN'(4);
            wr_rd  = 1'b1;
        end else if (bus.i_opcode[LUI]) begin
            rd_val = bus.i_imm;
            wr_rd  = 1'b1;
        end else if (bus.i_opcode[AUIPC]) begin
            rd_val = bus.i_pc + bus.i_imm;
            wr_rd  = 1'b1;
        end
        if (bus.i_rd_addr == 5'd0) wr_rd = 1'b0;

        if (bus.i_opcode[JALR]) begin
            next_pc   = (bus.i_rs1 + bus.i_imm) & ~XLEN'(1);
            change_pc = 1'b1;
        end else if (bus.i_opcode[JAL] | (bus.i_opcode[BRANCH] & (y == XLEN'(1)))) begin
            change_pc = 1'b1;
        end
    end

    // Next-state of the pipeline control flops; flush beats stall, redirect is a one-cycle pulse.
    always_comb begin
        ce_d        = bus.o_ce;
        wr_rd_d     = bus.o_wr_rd;
        change_pc_d = bus.o_change_pc;
        opcode_d    = update ? bus.i_opcode : bus.o_opcode;

        if (!stall)             ce_d = bus.i_flush ? 1'b0 : bus.i_ce;
        else if (!bus.i_stall)  ce_d = 1'b0;

        if (bus.i_flush)        wr_rd_d = 1'b0;
        else if (!stall)        wr_rd_d = bus.i_ce & wr_rd;

        if (bus.o_change_pc | bus.i_flush) change_pc_d = 1'b0;
        else if (!stall)                   change_pc_d = bus.i_ce & change_pc;

`ifdef ALU_FORWARD_EN
        rd_valid_d = wr_rd_d & ce_d & ~opcode_d[LOAD];
`else
        rd_valid_d = 1'b0;
`endif
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            bus.o_rs1_addr  <= '0;
            bus.o_rs1       <= '0;
            bus.o_rs2       <= '0;
            bus.o_imm       <= '0;
            bus.o_funct3    <= '0;
            bus.o_opcode    <= '0;
            bus.o_exception <= '0;
            bus.o_y         <= '0;
            bus.o_pc        <= '0;
            bus.o_next_pc   <= '0;
            bus.o_rd_addr   <= '0;
            bus.o_rd        <= '0;
            bus.o_ce        <= 1'b0;
            bus.o_wr_rd     <= 1'b0;
            bus.o_change_pc <= 1'b0;
            bus.o_rd_valid  <= 1'b0;
        end else begin
            if (update) begin
                bus.o_rs1_addr  <= bus.i_rs1_addr;
                bus.o_rs1       <= bus.i_rs1;
                bus.o_rs2       <= bus.i_rs2;
                bus.o_imm       <= bus.i_imm[11:0];
                bus.o_funct3    <= bus.i_funct3;
                bus.o_opcode    <= bus.i_opcode;
                bus.o_exception <= bus.i_exception;
                bus.o_y         <= y;
                bus.o_pc        <= bus.i_pc;
                bus.o_next_pc   <= next_pc;
                bus.o_rd_addr   <= bus.i_rd_addr;
                bus.o_rd        <= rd_val;
            end
            bus.o_ce        <= ce_d;
            bus.o_wr_rd     <= wr_rd_d;
            bus.o_change_pc <= change_pc_d;
            bus.o_rd_valid  <= rd_valid_d;
        end
    end

    assign bus.o_stall = stall & ~bus.i_flush;
    assign bus.o_flush = bus.i_flush;

    // Load-use hazard: the load in this stage has not produced rd yet.
    assign bus.o_stall_from_alu = bus.o_ce & bus.o_opcode[LOAD] & bus.i_ce &
                                  (bus.i_rs1_addr == bus.o_rd_addr) & (bus.o_rd_addr != 5'd0);

endmodule

// File: tb/tb_rv32i_alu.sv
// Self-checking bench for rv32i_alu: directed vector table, hand sequences and a randomized run against a reference model.
module tb_rv32i_alu;
    import rv32i_pkg::*;

    typedef struct {
        int          op;        // ALU op index, 14 = no op bit
        int          opc;       // opcode class index
        logic [31:0] rs1, rs2, imm, pc;
        logic [4:0]  rs1_addr, rd_addr;
        logic [2:0]  f3;
        logic [3:0]  exc;
        logic        ce, stall, force_stall, flush;
    } stim_t;

    typedef struct {
        logic [31:0] y, rd, npc;
        logic        wr, chg;
    } res_t;

    typedef struct {
        logic [31:0] y, rd, next_pc, rs1, rs2, pc;
        logic [11:0] imm;
        logic [4:0]  rs1_addr, rd_addr;
        logic [2:0]  f3;
        logic [10:0] opcode;
        logic [3:0]  exc;
        logic        ce, wr_rd, change_pc, rd_valid;
    } model_t;

    typedef struct {
        stim_t       s;
        logic [31:0] y, rd, npc;
        logic        wr, chg;
    } vec_t;

    logic clk;
    logic rst_n;
    rv32i_alu_if bus();

    rv32i_alu dut (.i_clk(clk), .i_rst_n(rst_n), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int     n_cmp = 0;
    int     n_bad = 0;
    stim_t  cur;
    model_t m;
    vec_t   vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic stim_t idle();
        stim_t s;
        s = '{op: 14, opc: SYSTEM, default: '0};
        return s;
    endfunction

    function automatic stim_t mk(input int op, input int opc, input logic [31:0] rs1, input logic [31:0] rs2,
                                 input logic [31:0] imm, input logic [31:0] pc, input logic [4:0] rd_addr);
        stim_t s;
        s = idle();
        s.op = op; s.opc = opc; s.rs1 = rs1; s.rs2 = rs2; s.imm = imm; s.pc = pc;
        s.rd_addr = rd_addr; s.ce = 1'b1;
        return s;
    endfunction

    // Reference: ALU operation by name, plain integer arithmetic
    function automatic logic [31:0] ref_alu(input int op, input logic [31:0] a, input logic [31:0] b);
        int sa, sb, sh;
        sa = int'(a); sb = int'(b); sh = int'(b % 32);
        case (op)
            0:  return a + b;
            1:  return a - b;
            2:  return (sa < sb) ? 32'd1 : 32'd0;
            3:  return (a < b) ? 32'd1 : 32'd0;
            4:  return a ^ b;
            5:  return a | b;
            6:  return a & b;
            7:  return a << sh;
            8:  return a >> sh;
            9:  return 32'(sa >>> sh);
            10: return (a == b) ? 32'd1 : 32'd0;
            11: return (a != b) ? 32'd1 : 32'd0;
            12: return (sa >= sb) ? 32'd1 : 32'd0;
            13: return (a >= b) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    function automatic res_t ref_exec(input stim_t s);
        res_t r;
        logic [31:0] a, b;
        a = (s.opc == JAL || s.opc == AUIPC) ? s.pc : s.rs1;
        b = (s.opc == RTYPE || s.opc == BRANCH) ? s.rs2 : s.imm;
        r.y = ref_alu(s.op, a, b);
        r.rd = 32'd0; r.wr = 1'b1;
        case (s.opc)
            RTYPE, ITYPE: r.rd = r.y;
            JAL, JALR:    r.rd = s.pc + 32'd4;
            LUI:          r.rd = s.imm;
            AUIPC:        r.rd = s.pc + s.imm;
            default:      r.wr = 1'b0;
        endcase
        if (s.rd_addr == 5'd0) r.wr = 1'b0;
        r.npc = s.pc + s.imm;
        r.chg = (s.opc == JAL) || (s.opc == JALR) || (s.opc == BRANCH && r.y == 32'd1);
        if (s.opc == JALR) r.npc = (s.rs1 + s.imm) & 32'hFFFF_FFFE;
        return r;
    endfunction

    task automatic apply(input stim_t s);
        cur = s;
        bus.i_alu         = 14'd1 << s.op;
        bus.i_opcode      = 11'd1 << s.opc;
        bus.i_rs1         = s.rs1;
        bus.i_rs2         = s.rs2;
        bus.i_imm         = s.imm;
        bus.i_pc          = s.pc;
        bus.i_rs1_addr    = s.rs1_addr;
        bus.i_rd_addr     = s.rd_addr;
        bus.i_funct3      = s.f3;
        bus.i_exception   = s.exc;
        bus.i_ce          = s.ce;
        bus.i_stall       = s.stall;
        bus.i_force_stall = s.force_stall;
        bus.i_flush       = s.flush;
    endtask

    task automatic model_reset();
        m = '{default: '0};
    endtask

    // Pipeline-register behaviour at one rising edge, from the current inputs
    task automatic model_edge();
        logic stl;
        res_t r;
        stl = cur.stall | cur.force_stall;
        r = ref_exec(cur);
        if (cur.ce && !stl) begin
            m.y = r.y; m.rd = r.rd; m.next_pc = r.npc;
            m.rs1 = cur.rs1; m.rs2 = cur.rs2; m.pc = cur.pc; m.imm = cur.imm[11:0];
            m.rs1_addr = cur.rs1_addr; m.rd_addr = cur.rd_addr; m.f3 = cur.f3;
            m.opcode = 11'd1 << cur.opc; m.exc = cur.exc;
        end
        if (m.change_pc || cur.flush) m.change_pc = 1'b0;
        else if (!stl)                m.change_pc = cur.ce & r.chg;
        if (cur.flush)   m.wr_rd = 1'b0;
        else if (!stl)   m.wr_rd = cur.ce & r.wr;
        if (!stl)              m.ce = cur.flush ? 1'b0 : cur.ce;
        else if (!cur.stall)   m.ce = 1'b0;
`ifdef ALU_FORWARD_EN
        m.rd_valid = m.wr_rd & m.ce & ~m.opcode[LOAD];
`else
        m.rd_valid = 1'b0;
`endif
    endtask

    task automatic check_regs();
        chk("o_ce", 32'(bus.o_ce), 32'(m.ce));
        chk("o_wr_rd", 32'(bus.o_wr_rd), 32'(m.wr_rd));
        chk("o_change_pc", 32'(bus.o_change_pc), 32'(m.change_pc));
        chk("o_rd_valid", 32'(bus.o_rd_valid), 32'(m.rd_valid));
        chk("o_y", bus.o_y, m.y);
        if (m.wr_rd) chk("o_rd", bus.o_rd, m.rd);
        if (m.change_pc) chk("o_next_pc", bus.o_next_pc, m.next_pc);
        chk("o_pc", bus.o_pc, m.pc);
        chk("o_rs1", bus.o_rs1, m.rs1);
        chk("o_rs2", bus.o_rs2, m.rs2);
        chk("o_imm", 32'(bus.o_imm), 32'(m.imm));
        chk("o_addrs", {22'd0, bus.o_rs1_addr, bus.o_rd_addr}, {22'd0, m.rs1_addr, m.rd_addr});
        chk("o_fields", {14'd0, bus.o_funct3, bus.o_opcode, bus.o_exception}, {14'd0, m.f3, m.opcode, m.exc});
    endtask

    task automatic check_comb();
        logic haz;
        haz = m.ce & m.opcode[LOAD] & cur.ce & (cur.rs1_addr == m.rd_addr) & (m.rd_addr != 5'd0);
        chk("o_stall", 32'(bus.o_stall), 32'((cur.stall | cur.force_stall) & ~cur.flush));
        chk("o_flush", 32'(bus.o_flush), 32'(cur.flush));
        chk("o_stall_from_alu", 32'(bus.o_stall_from_alu), 32'(haz));
    endtask

    // Called at posedge+1: drive, check combinational outputs before the edge
    task automatic drive(input stim_t s);
        apply(s);
        #3;
        check_comb();
    endtask

    task automatic clock();
        @(posedge clk);
        model_edge();
        #1;
        check_regs();
    endtask

    task automatic cycle(input stim_t s);
        drive(s);
        clock();
    endtask

    task automatic add_vec(input stim_t s, input logic [31:0] y, input logic [31:0] rd,
                           input logic wr, input logic [31:0] npc, input logic chg);
        vec_t v;
        v.s = s; v.y = y; v.rd = rd; v.wr = wr; v.npc = npc; v.chg = chg;
        vecs.push_back(v);
    endtask

    initial begin
        stim_t s;
        vec_t  v;

        // Directed table
        add_vec(mk(ADD, RTYPE, 5, 7, 0, 0, 1), 32'd12, 32'd12, 1, 0, 0);
        add_vec(mk(SUB, RTYPE, 5, 7, 0, 0, 1), 32'hFFFF_FFFE, 32'hFFFF_FFFE, 1, 0, 0);
        add_vec(mk(SRA, ITYPE, 32'h8000_0000, 0, 4, 0, 2), 32'hF800_0000, 32'hF800_0000, 1, 0, 0);
        add_vec(mk(SLTU, ITYPE, 1, 0, 32'hFFFF_FFFF, 0, 2), 32'd1, 32'd1, 1, 0, 0);
        add_vec(mk(SLT, ITYPE, 1, 0, 32'hFFFF_FFFF, 0, 2), 32'd0, 32'd0, 1, 0, 0);
        add_vec(mk(EQ, BRANCH, 3, 3, 32'h20, 32'h100, 0), 32'd1, 0, 0, 32'h120, 1);
        add_vec(mk(EQ, BRANCH, 3, 4, 32'h20, 32'h100, 0), 32'd0, 0, 0, 0, 0);
        add_vec(mk(ADD, JALR, 32'h1001, 0, 2, 32'h40, 3), 32'h1003, 32'h44, 1, 32'h1002, 1);
        add_vec(mk(ADD, LUI, 0, 0, 32'h1234_5000, 32'h80, 4), 32'h1234_5000, 32'h1234_5000, 1, 0, 0);
        add_vec(mk(ADD, JAL, 0, 0, 32'hFFFF_FFF8, 32'h200, 5), 32'h1F8, 32'h204, 1, 32'h1F8, 1);
        add_vec(mk(ADD, AUIPC, 0, 0, 32'h2000, 32'h1000, 6), 32'h3000, 32'h3000, 1, 0, 0);
        add_vec(mk(ADD, RTYPE, 1, 1, 0, 0, 0), 32'd2, 0, 0, 0, 0);
        add_vec(mk(GEU, BRANCH, 1, 32'hFFFF_FFFF, 32'hFFFF_FFF0, 32'h80, 0), 32'd0, 0, 0, 0, 0);
        add_vec(mk(GE, BRANCH, 1, 32'hFFFF_FFFF, 32'hFFFF_FFF0, 32'h80, 0), 32'd1, 0, 0, 32'h70, 1);
        add_vec(mk(NEQ, BRANCH, 3, 4, 8, 0, 0), 32'd1, 0, 0, 32'h8, 1);
        add_vec(mk(SRL, ITYPE, 32'h8000_0000, 0, 32'h24, 0, 7), 32'h0800_0000, 32'h0800_0000, 1, 0, 0);
        add_vec(mk(SLL, ITYPE, 1, 0, 31, 0, 7), 32'h8000_0000, 32'h8000_0000, 1, 0, 0);
        add_vec(mk(XOR, RTYPE, 32'hF0F0, 32'hFF00, 0, 0, 8), 32'h0FF0, 32'h0FF0, 1, 0, 0);
        add_vec(mk(OR, RTYPE, 32'hF0F0, 32'hFF00, 0, 0, 8), 32'hFFF0, 32'hFFF0, 1, 0, 0);
        add_vec(mk(AND, RTYPE, 32'hF0F0, 32'hFF00, 0, 0, 8), 32'hF000, 32'hF000, 1, 0, 0);
        add_vec(mk(14, RTYPE, 9, 9, 0, 0, 9), 32'd0, 32'd0, 1, 0, 0);

        // Reset held two cycles
        rst_n = 1'b0;
        apply(idle());
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_regs();
        chk("rst_o_ce", 32'(bus.o_ce), 32'd0);
        rst_n = 1'b1;
        cycle(idle());
        chk("idle_o_ce", 32'(bus.o_ce), 32'd0);

        foreach (vecs[i]) begin
            v = vecs[i];
            cycle(v.s);
            chk($sformatf("v%0d_y", i), bus.o_y, v.y);
            chk($sformatf("v%0d_wr_rd", i), 32'(bus.o_wr_rd), 32'(v.wr));
            chk($sformatf("v%0d_change_pc", i), 32'(bus.o_change_pc), 32'(v.chg));
            chk($sformatf("v%0d_ce", i), 32'(bus.o_ce), 32'd1);
            if (v.wr) chk($sformatf("v%0d_rd", i), bus.o_rd, v.rd);
            if (v.chg) chk($sformatf("v%0d_next_pc", i), bus.o_next_pc, v.npc);
            cycle(idle());
        end

        // Flush with a valid ADD
        s = mk(ADD, RTYPE, 5, 7, 0, 0, 3);
        s.flush = 1'b1;
        drive(s);
        chk("flush_o_flush", 32'(bus.o_flush), 32'd1);
        clock();
        chk("flush_o_ce", 32'(bus.o_ce), 32'd0);
        chk("flush_o_wr_rd", 32'(bus.o_wr_rd), 32'd0);

        // Downstream stall holds everything
        cycle(mk(ADD, RTYPE, 5, 7, 0, 0, 3));
        s = mk(SUB, RTYPE, 5, 7, 0, 0, 3);
        s.stall = 1'b1;
        drive(s);
        chk("stall_o_stall", 32'(bus.o_stall), 32'd1);
        clock();
        chk("stall_hold_y", bus.o_y, 32'd12);
        chk("stall_hold_ce", 32'(bus.o_ce), 32'd1);
        chk("stall_hold_wr", 32'(bus.o_wr_rd), 32'd1);

        // Forced stall alone inserts a bubble
        s.stall = 1'b0;
        s.force_stall = 1'b1;
        cycle(s);
        chk("fstall_o_ce", 32'(bus.o_ce), 32'd0);
        chk("fstall_hold_y", bus.o_y, 32'd12);

        // Flush during stall clears wr_rd and drops o_stall
        cycle(mk(ADD, RTYPE, 5, 7, 0, 0, 3));
        s = mk(ADD, RTYPE, 5, 7, 0, 0, 3);
        s.stall = 1'b1;
        s.flush = 1'b1;
        drive(s);
        chk("stflush_o_stall", 32'(bus.o_stall), 32'd0);
        clock();
        chk("stflush_wr_rd", 32'(bus.o_wr_rd), 32'd0);

        // Redirect is a single-cycle pulse even while stalled
        cycle(mk(ADD, JAL, 0, 0, 32'h10, 32'h200, 1));
        chk("pulse_first", 32'(bus.o_change_pc), 32'd1);
        chk("pulse_target", bus.o_next_pc, 32'h210);
        s = mk(ADD, JAL, 0, 0, 32'h10, 32'h300, 1);
        s.stall = 1'b1;
        cycle(s);
        chk("pulse_cleared", 32'(bus.o_change_pc), 32'd0);
        chk("pulse_hold_pc", bus.o_pc, 32'h200);

        // Load-use hazard, and no hazard against x0
        cycle(mk(ADD, LOAD, 32'h100, 0, 4, 0, 5));
        s = mk(ADD, RTYPE, 1, 2, 0, 0, 6);
        s.rs1_addr = 5'd5;
        drive(s);
        chk("loaduse_hazard", 32'(bus.o_stall_from_alu), 32'd1);
        clock();
        cycle(mk(ADD, LOAD, 32'h100, 0, 4, 0, 0));
        s.rs1_addr = 5'd0;
        drive(s);
        chk("loaduse_x0", 32'(bus.o_stall_from_alu), 32'd0);
        clock();

        // Randomized run against the reference model
        for (int n = 0; n < 600; n++) begin
            s.op          = int'($urandom_range(0, 14));
            s.opc         = int'($urandom_range(0, 10));
            if ($urandom_range(0, 3) == 0) s.opc = LOAD;
            s.rs1         = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
            s.rs2         = ($urandom_range(0, 3) == 0) ? s.rs1 : $urandom;
            s.imm         = ($urandom_range(0, 1) == 0) ? 32'($signed(12'($urandom))) : $urandom;
            s.pc          = $urandom & 32'hFFFF_FFFC;
            s.rd_addr     = 5'($urandom_range(0, 3));
            s.rs1_addr    = ($urandom_range(0, 1) == 0) ? m.rd_addr : 5'($urandom_range(0, 3));
            s.f3          = 3'($urandom);
            s.exc         = 4'd1 << $urandom_range(0, 4);
            s.ce          = ($urandom_range(0, 9) < 8);
            s.stall       = ($urandom_range(0, 9) == 0);
            s.force_stall = ($urandom_range(0, 9) == 0);
            s.flush       = ($urandom_range(0, 9) == 0);
            cycle(s);
        end

        // Asynchronous reset mid-operation
        cycle(mk(ADD, JAL, 0, 0, 32'h40, 32'h400, 7));
        drive(mk(ADD, RTYPE, 3, 4, 0, 0, 7));
        rst_n = 1'b0;
        #1;
        model_reset();
        check_regs();
        chk("midrst_o_ce", 32'(bus.o_ce), 32'd0);
        chk("midrst_o_y", bus.o_y, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cycle(mk(ADD, RTYPE, 3, 4, 0, 0, 7));
        chk("postrst_y", bus.o_y, 32'd7);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
